// File: rtl/cpu_sequencer.sv
// cpu_sequencer: four-phase instruction sequencer (FETCH, DECODE, EXECUTE,
// WRITEBACK). It owns the program counter, the instruction register, the
// sticky halt flag and a saturating count of retired instructions. Fetch
// requests go to program memory. The external control LUT decides through
// its InsLoad bit whether the fetched byte is accepted.
module cpu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_en,
  input  logic [7:0]  instr_data,
  input  logic        instr_valid,
  input  logic [15:0] control_signals,
  input  logic        branch_taken,
  input  logic [7:0]  branch_target,
  output logic [1:0]  state,
  output logic [7:0]  instruction,
  output logic [7:0]  pc,
  output logic        instr_req,
  output logic        halted,
  output logic [15:0] retired
);

  // Phase codes are visible on the state output, so the encoding is fixed.
  // All four values of the 2-bit register are legal phases, so no
  // unreachable encodings exist.
  typedef enum logic [1:0] {
    ST_FETCH     = 2'b00,
    ST_DECODE    = 2'b01,
    ST_EXECUTE   = 2'b10,
    ST_WRITEBACK = 2'b11
  } state_t;

  // Position of the InsLoad strobe inside the control word.
  localparam int INS_LOAD_BIT = 10;

  // Opcode patterns recognised by the sequencer itself. Every other opcode is
  // opaque here and only steers the control LUT.
  localparam logic [7:0] OP_NOP       = 8'h00;
  localparam logic [3:0] OP_HALT_LOW  = 4'hF;

  // Retired-instruction counter increment. The counter sticks at all-ones
  // rather than wrapping, so a long-running program never reports a
  // deceptively small count.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

  // Program counter advance after a fetch. It wraps naturally in 8 bits.
  function automatic logic [7:0] pc_inc8(input logic [7:0] v);
    return v + 8'd1;
  endfunction

  state_t      state_q,   state_d;
  logic [7:0]  ir_q,      ir_d;
  logic [7:0]  pc_q,      pc_d;
  logic        halted_q,  halted_d;
  logic [15:0] retired_q, retired_d;

  logic        fetch_req;
  logic        fetch_load;
  logic        ir_is_nop;
  logic        ir_is_halt;

  // Only InsLoad is consumed here. The remaining control-word bits drive the
  // datapath elsewhere and are folded into one deliberately unused net.
  logic ctrl_unused;
  assign ctrl_unused = ^{control_signals[15:INS_LOAD_BIT+1],
                         control_signals[INS_LOAD_BIT-1:0]};

  // Fetch request: only in FETCH, only while allowed to run and not halted.
  // It is also forced low while reset is held, regardless of run_en.
  always_comb begin
    fetch_req  = (state_q == ST_FETCH) && run_en && !halted_q && !rst;
    fetch_load = fetch_req && instr_valid && control_signals[INS_LOAD_BIT];
    ir_is_nop  = (ir_q == OP_NOP);
    ir_is_halt = (ir_q[3:0] == OP_HALT_LOW);
  end

  // Next-state and register-update logic. Everything holds unless a phase
  // explicitly changes it.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    pc_d      = pc_q;
    halted_d  = halted_q;
    retired_d = retired_q;

    case (state_q)
      ST_FETCH: begin
        // Stall here until memory delivers a byte that the control LUT
        // agrees to latch. instr_valid without a request is ignored.
        if (fetch_load) begin
          ir_d    = instr_data;
          pc_d    = pc_inc8(pc_q);
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        state_d = ST_EXECUTE;
      end

      ST_EXECUTE: begin
        if (ir_is_halt) begin
          // HALT ignores any branch request and does not count as retired.
          halted_d = 1'b1;
          state_d  = ST_FETCH;
        end else begin
          if (branch_taken) begin
            pc_d = branch_target;
          end
          if (ir_is_nop) begin
            // A no-op has nothing to write back, so it retires from here.
            retired_d = sat_inc16(retired_q);
            state_d   = ST_FETCH;
          end else begin
            state_d = ST_WRITEBACK;
          end
        end
      end

      ST_WRITEBACK: begin
        retired_d = sat_inc16(retired_q);
        state_d   = ST_FETCH;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Sequencer registers. Reset aborts any in-flight instruction at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      ir_q      <= 8'h00;
      pc_q      <= 8'h00;
      halted_q  <= 1'b0;
      retired_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      pc_q      <= pc_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

  // Output mapping.
  always_comb begin
    state       = state_q;
    instruction = ir_q;
    pc          = pc_q;
    instr_req   = fetch_req;
    halted      = halted_q;
    retired     = retired_q;
  end

endmodule
